// File: rtl/aes_pkg.sv
// Shared AES byte-stream definitions: block size, byte-counter width, FSM encodings
// and the ShiftRows / InvShiftRows address permutations used by both cipher directions.
package aes_pkg;

  localparam int AES_BLK_BYTES = 16;
  localparam int BYTE_CNT_W    = 4;

  // One-hot style encodings leave spare codes that the FSM steers back to LOAD.
  typedef enum logic [1:0] {
    ST_LOAD = 2'b01,
    ST_OUT  = 2'b10
  } sr_state_t;

  // Output position of input byte k = 4r+c under InvShiftRows: 4r + ((c+r) mod 4).
  function automatic logic [BYTE_CNT_W-1:0] inv_sr_idx(input logic [BYTE_CNT_W-1:0] k);
    logic [1:0] col;
    col = k[1:0] + k[3:2];
    return {k[3:2], col};
  endfunction

  // Output position of input byte k = 4r+c under ShiftRows: 4r + ((c-r) mod 4).
  function automatic logic [BYTE_CNT_W-1:0] fwd_sr_idx(input logic [BYTE_CNT_W-1:0] k);
    logic [1:0] col;
    col = k[1:0] - k[3:2];
    return {k[3:2], col};
  endfunction

endpackage

// File: rtl/aes_byte_buf.sv
// 16x8 state buffer: one synchronous write port, one asynchronous read port.
module aes_byte_buf
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_CNT_W-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [BYTE_CNT_W-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [AES_BLK_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inv_shift_row.sv
// Byte-serial AES InvShiftRows stage: permuted-write LOAD of 16 bytes, sequential OUT.
// Optional macro INV_SHIFT_ROW_FWD_EN adds a per-block fwd input selecting ShiftRows.
module inv_shift_row
  import aes_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef INV_SHIFT_ROW_FWD_EN
  input  logic             fwd,
`endif
  input  logic             en_din,
  input  logic [7:0]       din,
  output logic             en_dout,
  output logic [7:0]       dout,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             ovf
);

  sr_state_t             state_q, state_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic                  en_dout_q, en_dout_d;
  logic [7:0]            dout_q, dout_d;
  logic [CNT_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  we;
  logic [BYTE_CNT_W-1:0] waddr;
  logic [7:0]            rdata;

`ifdef INV_SHIFT_ROW_FWD_EN
  logic fwd_q, fwd_d, use_fwd;

  // Byte 0 sees the live fwd input; the rest of the block uses the value latched with it.
  assign use_fwd = (cnt_q == '0) ? fwd : fwd_q;
  assign waddr   = use_fwd ? fwd_sr_idx(cnt_q) : inv_sr_idx(cnt_q);
  assign fwd_d   = (state_q == ST_LOAD && en_din && cnt_q == '0) ? fwd : fwd_q;

  always_ff @(posedge clk) begin
    fwd_q <= fwd_d;
  end
`else
  assign waddr = inv_sr_idx(cnt_q);
`endif

  aes_byte_buf u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (cnt_q),
    .rdata (rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    en_dout_d = en_dout_q;
    dout_d    = dout_q;
    blk_cnt_d = blk_cnt_q;
    ovf_d     = ovf_q;
    we        = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        en_dout_d = 1'b0;
        drain_d   = 1'b0;
        if (en_din) begin
          we    = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(AES_BLK_BYTES - 1)) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (en_din) begin
          ovf_d = 1'b1;
        end
        // drain_q marks the 17th OUT edge that closes the block after byte 15 went out.
        if (drain_q) begin
          en_dout_d = 1'b0;
          drain_d   = 1'b0;
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          state_d   = ST_LOAD;
        end else begin
          en_dout_d = 1'b1;
          dout_d    = rdata;
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == 4'(AES_BLK_BYTES - 1)) begin
            drain_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_LOAD;
        cnt_d     = '0;
        drain_d   = 1'b0;
        en_dout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      en_dout_q <= 1'b0;
      dout_q    <= '0;
      blk_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      en_dout_q <= en_dout_d;
      dout_q    <= dout_d;
      blk_cnt_q <= blk_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign en_dout = en_dout_q;
  assign dout    = dout_q;
  assign busy    = (state_q == ST_OUT);
  assign blk_cnt = blk_cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_inv_shift_row.sv
// Scoreboard bench for inv_shift_row: expected bytes queued at block completion, popped on en_dout.
module tb_inv_shift_row;

  typedef logic [7:0] blk_t [16];

  logic       clk = 1'b0;
  logic       rst;
  logic       en_din;
  logic [7:0] din;
`ifdef INV_SHIFT_ROW_FWD_EN
  logic       fwd;
`endif

  logic       en_dout, busy, ovf;
  logic [7:0] dout;
  logic [7:0] blk_cnt;
  logic       en_dout2, busy2, ovf2;
  logic [7:0] dout2;
  logic [1:0] blk_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int run_len = 0;
  int exp_blk = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  inv_shift_row #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef INV_SHIFT_ROW_FWD_EN
    .fwd     (fwd),
`endif
    .en_din  (en_din),
    .din     (din),
    .en_dout (en_dout),
    .dout    (dout),
    .busy    (busy),
    .blk_cnt (blk_cnt),
    .ovf     (ovf)
  );

  inv_shift_row #(.CNT_W(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
`ifdef INV_SHIFT_ROW_FWD_EN
    .fwd     (fwd),
`endif
    .en_din  (en_din),
    .din     (din),
    .en_dout (en_dout2),
    .dout    (dout2),
    .busy    (busy2),
    .blk_cnt (blk_cnt2),
    .ovf     (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent row-rotation model: inverse out[4r+c]=in[4r+(c-r)], forward out[4r+c]=in[4r+(c+r)].
  function automatic int src_idx(input int k, input logic f);
    int r, c;
    r = k / 4;
    c = k % 4;
    return f ? 4 * r + ((c + r) % 4) : 4 * r + ((c - r + 4) % 4);
  endfunction

  function automatic void push_expected(input blk_t b, input logic f);
    for (int k = 0; k < 16; k++) exp_q.push_back(b[src_idx(k, f)]);
  endfunction

  always @(negedge clk) begin
    if (en_dout) begin
      run_len++;
      if (exp_q.size() == 0) begin
        check("spurious_en_dout", {31'd0, en_dout}, 32'd0);
      end else begin
        check("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end else begin
      if (run_len != 0) check("run_len", run_len, 16);
      run_len = 0;
    end
  end

  task automatic send_block(input blk_t b, input int gap, input logic f);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en_din = 1'b1;
      din    = b[i];
`ifdef INV_SHIFT_ROW_FWD_EN
      fwd    = f;
`endif
      @(posedge clk);
      if (i == 15) push_expected(b, f);
      if (gap > 0 && i != 15) begin
        @(negedge clk);
        en_din = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    en_din = 1'b0;
    @(posedge clk);
    #1;
    check("first_out_latency", {31'd0, en_dout}, 32'd1);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    if (!done) check("busy_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
    exp_blk++;
    check("queue_drained", exp_q.size(), 0);
    check("blk_cnt", {24'd0, blk_cnt}, exp_blk % 256);
    check("blk_cnt_w2", {30'd0, blk_cnt2}, exp_blk % 4);
  endtask

  task automatic do_block(input blk_t b, input int gap, input logic f);
    send_block(b, gap, f);
    wait_done();
  endtask

  function automatic blk_t seq_blk(input logic [7:0] base);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = base + 8'(i);
    return b;
  endfunction

  initial begin
    blk_t b;
    rst    = 1'b1;
    en_din = 1'b0;
    din    = 8'h00;
`ifdef INV_SHIFT_ROW_FWD_EN
    fwd    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_en_dout", {31'd0, en_dout}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_blk_cnt", {24'd0, blk_cnt}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Back-to-back block, then the same block with 3 idle cycles between bytes.
    do_block(seq_blk(8'h00), 0, 1'b0);
    do_block(seq_blk(8'h00), 3, 1'b0);
    check("ovf_clear", {31'd0, ovf}, 32'd0);

    // Stray byte while busy is dropped and flags ovf.
    send_block(seq_blk(8'h30), 0, 1'b0);
    check("busy_in_out", {31'd0, busy}, 32'd1);
    @(negedge clk);
    en_din = 1'b1;
    din    = 8'hAA;
    @(negedge clk);
    en_din = 1'b0;
    wait_done();
    check("ovf_set", {31'd0, ovf}, 32'd1);
    do_block(seq_blk(8'h10), 0, 1'b0);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset after a partial block discards it.
    b = seq_blk(8'h50);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      en_din = 1'b1;
      din    = b[i];
    end
    @(negedge clk);
    en_din = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_blk = 0;
    check("rst2_blk_cnt", {24'd0, blk_cnt}, 32'd0);
    check("rst2_ovf", {31'd0, ovf}, 32'd0);
    check("rst2_busy", {31'd0, busy}, 32'd0);
    do_block(seq_blk(8'h20), 0, 1'b0);

    // Four more blocks exercise the 2-bit counter wrap (1,2,3,0,1).
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
      do_block(b, n % 2, 1'b0);
    end

`ifdef INV_SHIFT_ROW_FWD_EN
    do_block(seq_blk(8'h00), 0, 1'b1);
    b = seq_blk(8'h00);
    for (int k = 0; k < 16; k++) b[k] = 8'(src_idx(k, 1'b1));
    do_block(b, 1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_shift_row.md
Name: inv_shift_row

Overview:
- Byte-serial AES InvShiftRows stage for the decryption datapath. It is the inverse of the encrypt-side ShiftRows stage.
- Collects one 16-byte state and applies the inverse row rotation. It then streams the 16 bytes out on consecutive cycles with a valid strobe.
- Uses the same en_din/din/en_dout/dout byte-stream convention as the other cipher stages. It chains directly after any stage that emits 16 back-to-back valid bytes.

Parameters:
- CNT_W, 8, width of the blocks-completed counter blk_cnt.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_din  in  1  input byte valid; din is captured on each edge where en_din=1 and state=LOAD.
- din  in  8  input byte, row-major: byte k = row k/4, column k%4.
- en_dout  out  1  output byte valid.
- dout  out  8  output byte, same row-major ordering.
- busy  out  1  high while in OUT state; upstream must hold en_din=0 while busy=1.
- blk_cnt  out  CNT_W  number of blocks fully emitted, wraps modulo 2^CNT_W.
- ovf  out  1  sticky flag: a byte was presented while busy.

Behaviour:
- Reset (rst=1 at an edge): state=LOAD, byte counter=0, en_dout=0, dout=0, blk_cnt=0, ovf=0.
  - Buffer contents are not reset (don't-care).
  - Reset mid-LOAD or mid-OUT discards the partial block; no further en_dout pulses follow.
- Transform: out[4r+c] = in[4r+((c-r) mod 4)], r,c in 0..3.
  - Row 0 is unchanged.
  - Row 1 rotates right by 1, row 2 by 2, row 3 by 3.
  - Equivalently, the output index of in[4r+c] is 4r+((c+r) mod 4).
  - The permutation is applied on the write address during LOAD, so OUT reads sequentially.
- FSM LOAD:
  - On en_din=1, write din to buf[perm(cnt)] and increment cnt.
  - Gaps (en_din=0) are allowed; cnt holds.
  - At the edge capturing byte 15 (edge E): cnt←0, state←OUT.
- FSM OUT:
  - Edges E+1..E+16 drive en_dout=1, dout=buf[0..15] in order, registered.
  - At edge E+17: en_dout←0, blk_cnt←blk_cnt+1, state←LOAD.
  - dout holds its last value while en_dout=0.
- Latency: first output byte is registered 1 edge after the last input byte. Block period is at least 16 input cycles + 17 cycles.
- busy = (state==OUT), decoded from the state register, so it is high at edges E+1..E+17.
  - en_din=1 at any edge while busy=1: the byte is dropped (buffer and cnt unchanged) and ovf←1.
  - The first byte of the next block is accepted no earlier than edge E+18.
- ovf stays set until rst.
- blk_cnt wraps from 2^CNT_W-1 to 0 with no other effect.
- Undefined state encodings return to LOAD with cnt=0 and en_dout=0.

Optional Feature:
- Macro: INV_SHIFT_ROW_FWD_EN.
- Defined: adds input port fwd (1 bit), sampled at the edge capturing byte 0 and held for the whole block.
  - fwd=1 applies the forward ShiftRows mapping: out[4r+c] = in[4r+((c+r) mod 4)].
  - fwd=0 applies the inverse mapping.
  - The same block can then serve both encrypt and decrypt datapaths.
- Not defined: no fwd port; inverse mapping only. Logic is identical to fwd=0.

Decomposition:
- Shared package aes_pkg:
  - AES_BLK_BYTES=16.
  - Byte-counter width 4.
  - FSM state encodings LOAD/OUT.
  - Functions inv_sr_idx(k) and fwd_sr_idx(k), each returning a 4-bit permuted address, shared with the encrypt-side stage.
- One natural sub-module, aes_byte_buf: 16x8 register file with one synchronous write port (addr, data, we) and one asynchronous read port.
- FSM, counters and flags stay in inv_shift_row.

Test Plan:
1. Reset, then send din=0x00..0x0F back-to-back. Required output on en_dout, in order: 00 01 02 03 07 04 05 06 0A 0B 08 09 0D 0E 0F 0C. en_dout high for exactly 16 consecutive cycles; blk_cnt=1.
2. Same 16 bytes with en_din idle 3 cycles between every byte. Output is identical to scenario 1, and the first output is 1 edge after the 16th capture.
3. Pulse en_din with din=0xAA during the OUT window (busy=1). ovf=1 and the stream is unchanged. The next block, 0x10..0x1F, yields 10 11 12 13 17 14 15 16 1A 1B 18 19 1D 1E 1F 1C.
4. Assert rst after 9 input bytes, then send a fresh block 0x20..0x2F. There is no en_dout before 16 new bytes arrive. Output is 20 21 22 23 27 24 25 26 2A 2B 28 29 2D 2E 2F 2C; blk_cnt=1.
5. With CNT_W=2, stream 5 blocks. blk_cnt reads 1,2,3,0,1 after each block.
6. With INV_SHIFT_ROW_FWD_EN and fwd=1, send 0x00..0x0F. Output is 00 01 02 03 05 06 07 04 0A 0B 08 09 0F 0C 0D 0E. Feeding that output back with fwd=0 returns 0x00..0x0F.
